// File: rtl/ahb_slave_wait_mem_if.sv
// AHB bus bundle for ahb_slave_wait_mem: address/control, write data,
// bus-level ready input and the slave's response signals.
interface ahb_slave_wait_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADYin;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic        HREADYout;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
        output HRDATA, HRESP, HREADYout
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
        input  HRDATA, HRESP, HREADYout
    );
endinterface

// File: rtl/ahb_slave_wait_mem.sv
// AHB slave responder: word-wide memory with programmable wait states on
// NONSEQ/SEQ data phases. Optional two-cycle ERROR response path enabled by
// defining AHB_SLAVE_ERR_RESP_EN; without it addresses wrap modulo
// SIZE_IN_BYTES, are forced aligned to HSIZE and HRESP is always OKAY.
module ahb_slave_wait_mem #(
    parameter int unsigned SIZE_IN_BYTES = 1024,
    parameter int unsigned WAIT_NSEQ     = 2,
    parameter int unsigned WAIT_SEQ      = 0
) (
    input logic                 HCLK,
    input logic                 HRESETn,
    ahb_slave_wait_mem_if.slave bus
);
    localparam int unsigned DEPTH = SIZE_IN_BYTES / 4;
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WN    = 4'(WAIT_NSEQ);
    localparam logic [3:0]  WS    = 4'(WAIT_SEQ);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
`ifdef AHB_SLAVE_ERR_RESP_EN
        ST_ERR1,
        ST_ERR2,
`endif
        ST_DATA
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q;
    logic [3:0]    be_q;
    logic          write_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          can_accept;
    logic [2:0]    sz;
    logic [1:0]    lo;
    logic [IW-1:0] in_idx;
    logic [3:0]    in_be;
    logic [3:0]    in_wait;
`ifdef AHB_SLAVE_ERR_RESP_EN
    logic          in_err;
`endif

    logic          mem_we;
    logic [IW-1:0] rd_idx;
    logic          rd_is_write;
    logic          rd_load;
    logic [31:0]   rd_word;

    // HBURST is accepted for protocol completeness but never affects addressing
    logic unused_burst;
    assign unused_burst = ^bus.HBURST;

    assign bus.HRDATA = rdata_q;

    // Address-phase decode: word index, byte lanes, wait count and error check
    always_comb begin
        sz      = (bus.HSIZE > 3'd2) ? 3'd2 : bus.HSIZE;
        in_idx  = IW'(bus.HADDR[31:2] & 30'(DEPTH - 1));
        in_wait = bus.HTRANS[0] ? WS : WN;
`ifdef AHB_SLAVE_ERR_RESP_EN
        lo      = bus.HADDR[1:0];
        in_err  = (bus.HADDR >= 32'(SIZE_IN_BYTES)) || (bus.HSIZE > 3'd2) ||
                  ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                  ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
`else
        case (sz)
            3'd0:    lo = bus.HADDR[1:0];
            3'd1:    lo = {bus.HADDR[1], 1'b0};
            default: lo = 2'b00;
        endcase
`endif
        case (sz)
            3'd0:    in_be = 4'b0001 << lo;
            3'd1:    in_be = lo[1] ? 4'b1100 : 4'b0011;
            default: in_be = 4'b1111;
        endcase
        accept = bus.HSEL & bus.HREADYin & bus.HTRANS[1] & can_accept;
    end

    // Per-state bus response; a new address phase is only taken while ready
    always_comb begin
        bus.HREADYout = 1'b1;
        bus.HRESP     = 2'b00;
        can_accept    = 1'b1;
        case (state_q)
            ST_WAIT: begin
                bus.HREADYout = 1'b0;
                can_accept    = 1'b0;
            end
`ifdef AHB_SLAVE_ERR_RESP_EN
            ST_ERR1: begin
                bus.HREADYout = 1'b0;
                bus.HRESP     = 2'b01;
                can_accept    = 1'b0;
            end
            ST_ERR2: bus.HRESP = 2'b01;
`endif
            default: ;
        endcase
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q <= 4'd1) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
`ifdef AHB_SLAVE_ERR_RESP_EN
            ST_ERR1: state_d = ST_ERR2;
`endif
            default: begin
                if (accept) begin
`ifdef AHB_SLAVE_ERR_RESP_EN
                    if (in_err) state_d = ST_ERR1;
                    else
`endif
                    if (in_wait != 4'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = in_wait;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Read word for the upcoming data cycle; a write completing on the same
    // edge is forwarded so back-to-back write/read of one word sees new data
    always_comb begin
        mem_we      = (state_q == ST_DATA) && write_q;
        rd_idx      = accept ? in_idx : idx_q;
        rd_is_write = accept ? bus.HWRITE : write_q;
        rd_load     = (state_d == ST_DATA) && !rd_is_write;
        rd_word     = mem[rd_idx];
        for (int unsigned b = 0; b < 4; b++) begin
            if (mem_we && (idx_q == rd_idx) && be_q[b])
                rd_word[8*b +: 8] = bus.HWDATA[8*b +: 8];
        end
    end

    // State, counter, latched address-phase control and read data register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= in_idx;
                be_q    <= in_be;
                write_q <= bus.HWRITE;
            end
            if (rd_load) rdata_q <= rd_word;
        end
    end

    // Memory write on the completing data cycle, byte lanes from address phase
    always_ff @(posedge HCLK) begin
        if (mem_we && HRESETn) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_wait_mem.sv
// Scoreboard bench for ahb_slave_wait_mem: a byte-array reference model
// predicts response, wait count and read data per transfer; a monitor
// process checks each completed data phase against the queued prediction.
module tb_ahb_slave_wait_mem;
    localparam int unsigned SIZE = 1024;
    localparam int unsigned WN   = 2;
    localparam int unsigned WS   = 0;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int unsigned waits;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_slave_wait_mem_if bus();
    assign bus.HREADYin = bus.HREADYout;

    ahb_slave_wait_mem #(
        .SIZE_IN_BYTES(SIZE),
        .WAIT_NSEQ(WN),
        .WAIT_SEQ(WS)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .bus(bus)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [7:0]  mmem [SIZE];
    logic [31:0] last_rd = '0;
    bit          mon_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference model: applies one transfer to the byte array, returns the response
    function automatic exp_t model(input logic [1:0] trans, input logic [31:0] addr,
                                   input logic wr, input logic [2:0] size, input logic [31:0] wdata);
        exp_t        e;
        int unsigned nb, a, base;
        nb      = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
        e.rdata = last_rd;
        e.resp  = 2'b00;
        e.waits = trans[0] ? WS : WN;
`ifdef AHB_SLAVE_ERR_RESP_EN
        if (addr >= SIZE || size > 3'd2 || (addr % nb) != 0) begin
            e.resp  = 2'b01;
            e.waits = 1;
            return e;
        end
        a = addr;
`else
        a = addr % SIZE;
        a = a - (a % nb);
`endif
        if (wr) begin
            for (int unsigned k = 0; k < nb; k++)
                mmem[a + k] = wdata[8*((a + k) % 4) +: 8];
        end else begin
            base    = a - (a % 4);
            last_rd = {mmem[base + 3], mmem[base + 2], mmem[base + 1], mmem[base]};
            e.rdata = last_rd;
        end
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        forever begin
            @(negedge HCLK);
            if (bus.HREADYout === 1'b1) break;
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: HREADYout stuck at %b, required 1", bus.HREADYout);
                break;
            end
        end
        @(posedge HCLK);
        #1;
    endtask

    // Drive one address phase; on return this transfer is in its data phase
    task automatic issue(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic wr, input logic [2:0] size, input logic [31:0] wdata);
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HBURST = 3'($urandom_range(0, 7));
        if (sel && trans[1]) q.push_back(model(trans, addr, wr, size, wdata));
        wait_ready();
        bus.HWDATA = wdata;
    endtask

    task automatic idle();
        issue(1'b0, T_IDLE, $urandom, 1'b0, 3'd2, $urandom);
    endtask

    // Monitor: tracks data phases from the bus and compares on completion
    initial begin
        bit   dp = 1'b0;
        bit   rdy_n = 1'b1;
        int   wcnt = 0;
        exp_t e;
        forever begin
            @(posedge HCLK);
            if (!HRESETn) dp = 1'b0;
            else if (rdy_n) begin
                dp   = bus.HSEL && bus.HTRANS[1];
                wcnt = 0;
            end
            @(negedge HCLK);
            rdy_n = bus.HREADYout;
            if (mon_en && HRESETn) begin
                if (dp) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_data_phase: got data phase with empty queue, required none");
                        dp = 1'b0;
                    end else if (!bus.HREADYout) begin
                        wcnt++;
                        check("wait_resp", 32'(bus.HRESP), 32'(q[0].resp));
                    end else begin
                        e = q.pop_front();
                        check("wait_count", 32'(wcnt), 32'(e.waits));
                        check("resp", 32'(bus.HRESP), 32'(e.resp));
                        check("rdata", bus.HRDATA, e.rdata);
                    end
                end else begin
                    check("idle_ready", 32'(bus.HREADYout), 32'd1);
                    check("idle_resp", 32'(bus.HRESP), 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;
        int unsigned nb, r;

        bus.HSEL   = 1'b0;
        bus.HTRANS = T_IDLE;
        bus.HADDR  = '0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd2;
        bus.HBURST = '0;
        bus.HWDATA = '0;

        repeat (3) @(posedge HCLK);
        #1;
        check("reset_ready", 32'(bus.HREADYout), 32'd1);
        check("reset_resp", 32'(bus.HRESP), 32'd0);
        check("reset_rdata", bus.HRDATA, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        mon_en = 1'b1;

        // Fill the whole memory with INCR16 word bursts
        for (int b = 0; b < int'(SIZE / 64); b++)
            for (int w = 0; w < 16; w++)
                issue(1'b1, (w == 0) ? T_NSEQ : T_SEQ, 32'((b * 16 + w) * 4), 1'b1, 3'd2, $urandom);
        idle();

        // Single NONSEQ write and readback
        issue(1'b1, T_NSEQ, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        idle();
        issue(1'b1, T_NSEQ, 32'h10, 1'b0, 3'd2, $urandom);
        idle();

        // INCR4 write then INCR4 read
        for (int i = 0; i < 4; i++)
            issue(1'b1, (i == 0) ? T_NSEQ : T_SEQ, 32'(32'h20 + 4 * i), 1'b1, 3'd2, 32'(32'h11 * (i + 1)));
        for (int i = 0; i < 4; i++)
            issue(1'b1, (i == 0) ? T_NSEQ : T_SEQ, 32'(32'h20 + 4 * i), 1'b0, 3'd2, $urandom);
        idle();

        // Byte write into a zeroed word
        issue(1'b1, T_NSEQ, 32'h30, 1'b1, 3'd2, 32'h00000000);
        issue(1'b1, T_NSEQ, 32'h31, 1'b1, 3'd0, 32'h0000AB00);
        issue(1'b1, T_NSEQ, 32'h30, 1'b0, 3'd2, $urandom);
        idle();

        // Out-of-range read followed directly by a valid read
        issue(1'b1, T_NSEQ, 32'(SIZE), 1'b0, 3'd2, $urandom);
        issue(1'b1, T_NSEQ, 32'h10, 1'b0, 3'd2, $urandom);
        idle();

        // Unselected and IDLE/BUSY transfers must leave memory untouched
        issue(1'b0, T_NSEQ, 32'h10, 1'b1, 3'd2, 32'h0BAD0BAD);
        issue(1'b1, T_BUSY, 32'h10, 1'b1, 3'd2, 32'h0BAD0BAD);
        issue(1'b1, T_IDLE, 32'h10, 1'b1, 3'd2, 32'h0BAD0BAD);
        issue(1'b1, T_NSEQ, 32'h10, 1'b0, 3'd2, $urandom);
        idle();

        // Reset during the second wait cycle of a write aborts it
        mon_en     = 1'b0;
        bus.HSEL   = 1'b1;
        bus.HTRANS = T_NSEQ;
        bus.HADDR  = 32'h40;
        bus.HWRITE = 1'b1;
        bus.HSIZE  = 3'd2;
        @(posedge HCLK);
        #1;
        bus.HWDATA = 32'h5A5A5A5A;
        bus.HSEL   = 1'b0;
        bus.HTRANS = T_IDLE;
        check("rst_wait1_ready", 32'(bus.HREADYout), 32'd0);
        @(posedge HCLK);
        #3;
        check("rst_wait2_ready", 32'(bus.HREADYout), 32'd0);
        HRESETn = 1'b0;
        #1;
        check("rst_abort_ready", 32'(bus.HREADYout), 32'd1);
        check("rst_abort_resp", 32'(bus.HRESP), 32'd0);
        check("rst_abort_rdata", bus.HRDATA, 32'd0);
        last_rd = '0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        mon_en = 1'b1;
        issue(1'b1, T_NSEQ, 32'h40, 1'b0, 3'd2, $urandom);
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            tr = (r < 1) ? T_IDLE : (r < 2) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ;
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
            nb = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
            a  = 32'($urandom_range(0, SIZE - 1));
            if ($urandom_range(0, 99) < 85) a = a - (a % nb);
            if ($urandom_range(0, 99) < 5) a = a + 32'(SIZE * $urandom_range(1, 3));
            issue($urandom_range(0, 99) < 85, tr, a, 1'($urandom_range(0, 1)), sz, $urandom);
        end
        idle();
        idle();

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
